// File: rtl/mul_unit.sv
// Iterative radix-2 shift-add multiplier serving MUL, UMULL and SMULL.
// Operands are converted to sign-magnitude at issue, multiplied unsigned over
// WIDTH cycles, then the sign is reapplied in a single fix-up cycle.
module mul_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             Start,
    input  logic [2:0]       MulOp,
    input  logic [WIDTH-1:0] SrcA,
    input  logic [WIDTH-1:0] SrcB,
    output logic             Busy,
    output logic             Done,
    output logic [WIDTH-1:0] ResultLo,
    output logic [WIDTH-1:0] ResultHi,
    output logic [1:0]       MulFlags
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST     = CW'(WIDTH - 1);
    localparam logic [2:0]    OP_MUL   = 3'b101;
    localparam logic [2:0]    OP_UMULL = 3'b110;
    localparam logic [2:0]    OP_SMULL = 3'b111;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX, S_DONE} state_t;

    state_t             state, state_nxt;
    logic [2:0]         op;
    logic               neg;
    logic [WIDTH-1:0]   mcand;
    // acc_lo starts as the multiplier and fills with product bits as it shifts
    logic [WIDTH-1:0]   acc_hi, acc_lo;
    logic [CW-1:0]      cnt;

    logic               legal, accept;
    logic [WIDTH-1:0]   mag_a, mag_b;
    logic [WIDTH:0]     sum;
    logic [2*WIDTH-1:0] acc, prod;

    assign legal  = (MulOp == OP_MUL) || (MulOp == OP_UMULL) || (MulOp == OP_SMULL);
    assign accept = (state == S_IDLE) && Start && legal;

    // Absolute values for SMULL; -(2^(W-1)) maps to 2^(W-1) as an unsigned value
    assign mag_a = ((MulOp == OP_SMULL) && SrcA[WIDTH-1]) ? -SrcA : SrcA;
    assign mag_b = ((MulOp == OP_SMULL) && SrcB[WIDTH-1]) ? -SrcB : SrcB;

    // Extra top bit holds the adder carry so the shifted-in bit is never lost
    assign sum  = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, mcand} : '0);
    assign acc  = {acc_hi, acc_lo};
    assign prod = neg ? -acc : acc;

    assign Busy = (state == S_RUN) || (state == S_FIX);
    assign Done = (state == S_DONE);

    // State register
    always_ff @(posedge clk) begin
        if (reset) state <= S_IDLE;
        else       state <= state_nxt;
    end

    // Next-state decode: WIDTH run cycles, one fix-up cycle, one done cycle
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (accept) state_nxt = S_RUN;
            S_RUN:   if (cnt == LAST) state_nxt = S_FIX;
            S_FIX:   state_nxt = S_DONE;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Datapath: operand capture, shift-add iteration, result/flag registration
    always_ff @(posedge clk) begin
        if (reset) begin
            op       <= '0;
            neg      <= 1'b0;
            mcand    <= '0;
            acc_hi   <= '0;
            acc_lo   <= '0;
            cnt      <= '0;
            ResultLo <= '0;
            ResultHi <= '0;
            MulFlags <= 2'b00;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        op     <= MulOp;
                        neg    <= (MulOp == OP_SMULL) && (SrcA[WIDTH-1] ^ SrcB[WIDTH-1]);
                        mcand  <= mag_a;
                        acc_hi <= '0;
                        acc_lo <= mag_b;
                        cnt    <= '0;
                    end
                end
                S_RUN: begin
                    acc_hi <= sum[WIDTH:1];
                    acc_lo <= {sum[0], acc_lo[WIDTH-1:1]};
                    cnt    <= cnt + CW'(1);
                end
                S_FIX: begin
                    ResultLo <= prod[WIDTH-1:0];
                    if (op == OP_MUL) begin
                        ResultHi <= '0;
                        MulFlags <= {prod[WIDTH-1], prod[WIDTH-1:0] == '0};
                    end else begin
                        ResultHi <= prod[2*WIDTH-1:WIDTH];
                        MulFlags <= {prod[2*WIDTH-1], prod == '0};
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
